// File: rtl/axis_word_packer.sv
// axis_word_packer: packs WORD_W-bit words into WORDS-slot phrases with keep/tuser/tlast and a registered output stage.
module axis_word_packer #(
  parameter int WORD_W = 16,
  parameter int WORDS = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [WORD_W-1:0]         data_in,
  input  logic                      newframe_in,
  input  logic                      last_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [WORD_W*WORDS-1:0]   data_out,
  output logic [WORDS-1:0]          keep_out,
  output logic                      tuser_out,
  output logic                      tlast_out
);
  localparam int PHRASE_W = WORD_W * WORDS;
  localparam int CW = $clog2(WORDS + 1);
  logic [WORD_W-1:0] slot [WORDS];
  logic [CW-1:0] cnt, wr_idx;
  logic first_user, closed, full, busy, out_free, flush_req, move, accept;
  logic [PHRASE_W-1:0] phrase;
  logic [WORDS-1:0] keep;
  always_comb begin
    full = cnt == CW'(WORDS);
    busy = cnt != '0;
    out_free = ~valid_out | ready_out;
    flush_req = valid_in & newframe_in & busy;
    move = busy & (full | closed | flush_req) & out_free;
    ready_in = move | (~full & ~closed & ~(newframe_in & busy));
    accept = valid_in & ready_in;
    wr_idx = move ? '0 : cnt;
  end
  for (genvar i = 0; i < WORDS; i++) begin : g_slot
    assign phrase[(MSB_FIRST != 0 ? WORDS - 1 - i : i) * WORD_W +: WORD_W] = slot[i];
    assign keep[i] = cnt > CW'(i);
  end
  // A word arriving in a move cycle lands in slot 0 of the freshly cleared assembly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      data_out <= '0;
      keep_out <= '0;
      tuser_out <= 1'b0;
      tlast_out <= 1'b0;
      cnt <= '0;
      first_user <= 1'b0;
      closed <= 1'b0;
      for (int i = 0; i < WORDS; i++) slot[i] <= '0;
    end else begin
      if (move) begin
        valid_out <= 1'b1;
        data_out <= phrase;
        keep_out <= keep;
        tuser_out <= first_user;
        tlast_out <= closed;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
      for (int i = 0; i < WORDS; i++)
        slot[i] <= (accept && wr_idx == CW'(i)) ? data_in : (move ? '0 : slot[i]);
      cnt <= accept ? wr_idx + 1'b1 : (move ? '0 : cnt);
      closed <= accept ? last_in : (move ? 1'b0 : closed);
      first_user <= (accept && wr_idx == '0) ? newframe_in : (move ? 1'b0 : first_user);
    end
  end
endmodule

// File: tb/tb_axis_word_packer.sv
// tb_axis_word_packer: directed checks on an 8-word MSB-first packer plus random sweeps of 4-word and 1-word LSB-first packers.
module tb_axis_word_packer;
  localparam int WW = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, stalls = 0, sweep_done = 0;
  bit sweep_go = 1'b0;
  logic v0 = 1'b0, nf0 = 1'b0, l0 = 1'b0, ro0 = 1'b1;
  logic [WW-1:0] d0 = '0;
  typedef struct {logic [127:0] d; logic [7:0] k; logic u, l;} obs_t;
  obs_t obs0[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int N = k == 0 ? 8 : (k == 1 ? 4 : 1);
    localparam int M = k == 0 ? 1 : 0;
    localparam int PW = WW * N;
    typedef struct {logic [PW-1:0] d; logic [N-1:0] keep; logic u, l;} ph_t;
    logic valid_in, ready_in, newframe_in, last_in, valid_out, ready_out, tuser_out, tlast_out;
    logic [WW-1:0] data_in;
    logic [PW-1:0] data_out;
    logic [N-1:0] keep_out;
    ph_t exp_q[$];
    logic [PW-1:0] md = '0;
    int mc = 0, got = 0;
    logic mu = 1'b0, took = 1'b0;

    axis_word_packer #(.WORD_W(WW), .WORDS(N), .MSB_FIRST(M)) dut (
      .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .newframe_in(newframe_in), .last_in(last_in), .valid_out(valid_out), .ready_out(ready_out),
      .data_out(data_out), .keep_out(keep_out), .tuser_out(tuser_out), .tlast_out(tlast_out));

    task automatic emit(input logic lst);
      ph_t p;
      p.d = md;
      p.keep = '0;
      for (int i = 0; i < mc; i++) p.keep[i] = 1'b1;
      p.u = mu;
      p.l = lst;
      exp_q.push_back(p);
      md = '0;
      mc = 0;
      mu = 1'b0;
    endtask

    // Phrase boundaries follow from the accepted word stream alone: full, last, or a newframe on a non-empty phrase.
    always @(negedge clk) begin
      took = valid_in & ready_in;
      if (rst) begin
        exp_q.delete();
        md = '0;
        mc = 0;
        mu = 1'b0;
      end else begin
        if (valid_out && ready_out) begin
          got++;
          if (k == 0) obs0.push_back('{128'(data_out), 8'(keep_out), tuser_out, tlast_out});
          if (exp_q.size() == 0) chk("sb_unexpected_phrase", 128'(data_out), 0);
          else begin
            ph_t e;
            e = exp_q.pop_front();
            chk("sb_data", 128'(data_out), 128'(e.d));
            chk("sb_keep", 128'(keep_out), 128'(e.keep));
            chk("sb_tuser", 128'(tuser_out), 128'(e.u));
            chk("sb_tlast", 128'(tlast_out), 128'(e.l));
          end
        end
        if (took) begin
          if (newframe_in && mc > 0) emit(1'b0);
          md[(M != 0 ? PW - (mc + 1) * WW : mc * WW) +: WW] = data_in;
          if (mc == 0) mu = newframe_in;
          mc++;
          if (last_in || mc == N) emit(last_in);
        end
      end
    end

    if (k == 0) begin : drv0
      assign valid_in = v0;
      assign data_in = d0;
      assign newframe_in = nf0;
      assign last_in = l0;
      assign ready_out = ro0;
    end else begin : drvr
      initial begin
        valid_in = 1'b0; data_in = '0; newframe_in = 1'b0; last_in = 1'b0; ready_out = 1'b1;
        wait (sweep_go);
        for (int c = 0; c < 800; c++) begin
          @(posedge clk); #1;
          if (!valid_in || took) begin
            valid_in = $urandom_range(0, 9) < 7;
            data_in = WW'($urandom);
            newframe_in = $urandom_range(0, 4) == 0;
            last_in = $urandom_range(0, 4) == 0;
          end
          ready_out = $urandom_range(0, 9) < 6;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        repeat (20) @(posedge clk);
        chk("sweep_drained", 128'(exp_q.size()), 0);
        chk("sweep_active", 128'(got > 20), 1);
        sweep_done++;
      end
    end
  end

  function automatic logic [127:0] mkfull(input logic [15:0] base);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[127 - 16 * i -: 16] = base + 16'(i);
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input logic nf, input logic l);
    int n = 0;
    v0 = 1'b1; d0 = d; nf0 = nf; l0 = l;
    @(negedge clk);
    while (!g[0].ready_in && n < 100) begin n++; @(negedge clk); end
    stalls += n;
    if (n >= 100) chk("send_timeout", 128'(n), 0);
    @(posedge clk); #1;
    v0 = 1'b0; nf0 = 1'b0; l0 = 1'b0;
  endtask

  task automatic get_phrase(input logic [127:0] d, input logic [7:0] kp, input logic u, input logic l);
    int n = 0;
    obs_t o;
    while (obs0.size() == 0 && n < 50) begin @(negedge clk); n++; end
    if (obs0.size() == 0) chk("phrase_timeout", 0, 1);
    else begin
      o = obs0.pop_front();
      chk("ph_data", o.d, d);
      chk("ph_keep", 128'(o.k), 128'(kp));
      chk("ph_tuser", 128'(o.u), 128'(u));
      chk("ph_tlast", 128'(o.l), 128'(l));
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst_valid", 128'(g[0].valid_out), 0);
    chk("rst_data", g[0].data_out, 0);
    chk("rst_keep", 128'(g[0].keep_out), 0);
    chk("rst_tuser", 128'(g[0].tuser_out), 0);
    chk("rst_tlast", 128'(g[0].tlast_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 128'(g[0].ready_in), 1);
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) send(16'(i), i == 1, 1'b0);
    for (int i = 1; i <= 3; i++) send(16'hB000 + 16'(i), 1'b0, 1'b0);
    send(16'hAAAA, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) send(16'hC000 + 16'(i), 1'b0, i == 4);
    send(16'hD001, 1'b0, 1'b0);
    send(16'hD002, 1'b0, 1'b0);
    chk("no_stall", 128'(stalls), 0);
    get_phrase(mkfull(16'h0001), 8'hFF, 1'b1, 1'b0);
    get_phrase({16'hB001, 16'hB002, 16'hB003, 80'h0}, 8'h07, 1'b0, 1'b0);
    get_phrase({16'hAAAA, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 48'h0}, 8'h1F, 1'b1, 1'b1);
    ro0 = 1'b0;
    for (int i = 2; i < 16; i++) send(16'hD001 + 16'(i), 1'b0, 1'b0);
    chk("bp_no_stall", 128'(stalls), 0);
    v0 = 1'b1; d0 = 16'hD011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_ready_in", 128'(g[0].ready_in), 0);
      chk("hold_valid", 128'(g[0].valid_out), 1);
      chk("hold_data", g[0].data_out, mkfull(16'hD001));
    end
    @(posedge clk); #1;
    ro0 = 1'b1;
    send(16'hD011, 1'b0, 1'b0);
    get_phrase(mkfull(16'hD001), 8'hFF, 1'b0, 1'b0);
    get_phrase(mkfull(16'hD009), 8'hFF, 1'b0, 1'b0);
    ro0 = 1'b0;
    for (int i = 0; i < 7; i++) send(16'hD012 + 16'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) send(16'hE000 + 16'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 128'(g[0].valid_out), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 128'(g[0].valid_out), 0);
    chk("mid_rst_keep", 128'(g[0].keep_out), 0);
    chk("mid_rst_data", g[0].data_out, 0);
    @(posedge clk); #1;
    ro0 = 1'b1;
    for (int i = 0; i < 8; i++) send(16'hF001 + 16'(i), 1'b0, 1'b0);
    get_phrase(mkfull(16'hF001), 8'hFF, 1'b0, 1'b0);
    chk("no_extra_phrase", 128'(obs0.size()), 0);
    sweep_go = 1'b1;
    n = 0;
    while (sweep_done < 2 && n < 5000) begin @(posedge clk); n++; end
    chk("sweep_done", 128'(sweep_done), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
